// File: rtl/shift_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : shift_issue_stage
//  Brief    : Decodes MIPS R-type shift functs into barrel-shifter operands,
//             holding them in issue slot S0 and capturing results in slot S1.
//  Revision : 1.0  initial release
// ============================================================================
module shift_issue_stage #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         funct,
    input  logic [4:0]         shamt,
    input  logic [31:0]        rs_val,
    input  logic [31:0]        rt_val,
    output logic [31:0]        sh_a,
    output logic [4:0]         sh_b,
    output logic [1:0]         sh_aluc,
    input  logic [31:0]        sh_c,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_result,
    output logic               out_illegal,
    output logic [COUNT_W-1:0] shift_count
);

    localparam logic [1:0] C_ALUC_SRA = 2'b00;
    localparam logic [1:0] C_ALUC_SRL = 2'b10;
    localparam logic [1:0] C_ALUC_SLL = 2'b01;

    logic               s0_valid_q, s0_valid_d;
    logic [31:0]        s0_a_q, s0_a_d;
    logic [4:0]         s0_b_q, s0_b_d;
    logic [1:0]         s0_aluc_q, s0_aluc_d;
    logic               s0_ill_q, s0_ill_d;
    logic               s1_valid_q, s1_valid_d;
    logic [31:0]        s1_result_q, s1_result_d;
    logic               s1_ill_q, s1_ill_d;
    logic [COUNT_W-1:0] shift_count_q, shift_count_d;

    logic [4:0] w_dec_b;
    logic [1:0] w_dec_aluc;
    logic       w_dec_ill;
    logic       w_s1_free;
    logic       w_s0_adv;
    logic       w_accept;
    logic       w_fire;

    always_comb begin
        w_dec_b    = shamt;
        w_dec_aluc = C_ALUC_SLL;
        w_dec_ill  = 1'b0;
        unique case (funct)
            6'b000000: begin w_dec_b = shamt;       w_dec_aluc = C_ALUC_SLL; end
            6'b000010: begin w_dec_b = shamt;       w_dec_aluc = C_ALUC_SRL; end
            6'b000011: begin w_dec_b = shamt;       w_dec_aluc = C_ALUC_SRA; end
            6'b000100: begin w_dec_b = rs_val[4:0]; w_dec_aluc = C_ALUC_SLL; end
            6'b000110: begin w_dec_b = rs_val[4:0]; w_dec_aluc = C_ALUC_SRL; end
            6'b000111: begin w_dec_b = rs_val[4:0]; w_dec_aluc = C_ALUC_SRA; end
            // Non-shift functs become a zero-distance left shift, passing rt through.
            default:   begin w_dec_b = 5'd0;        w_dec_aluc = C_ALUC_SLL; w_dec_ill = 1'b1; end
        endcase
    end

    always_comb begin
        w_s1_free = !s1_valid_q || out_ready;
        w_s0_adv  = s0_valid_q && w_s1_free;
        in_ready  = !rst && (!s0_valid_q || w_s0_adv);
        w_accept  = in_valid && in_ready;
        w_fire    = s1_valid_q && out_ready && !s1_ill_q;
    end

    always_comb begin
        s0_valid_d    = s0_valid_q;
        s0_a_d        = s0_a_q;
        s0_b_d        = s0_b_q;
        s0_aluc_d     = s0_aluc_q;
        s0_ill_d      = s0_ill_q;
        s1_valid_d    = s1_valid_q;
        s1_result_d   = s1_result_q;
        s1_ill_d      = s1_ill_q;
        shift_count_d = shift_count_q;

        if (w_accept) begin
            s0_valid_d = 1'b1;
            s0_a_d     = rt_val;
            s0_b_d     = w_dec_b;
            s0_aluc_d  = w_dec_aluc;
            s0_ill_d   = w_dec_ill;
        end else if (w_s0_adv) begin
            s0_valid_d = 1'b0;
        end

        if (w_s0_adv) begin
            s1_valid_d  = 1'b1;
            s1_result_d = sh_c;
            s1_ill_d    = s0_ill_q;
        end else if (s1_valid_q && out_ready) begin
            s1_valid_d = 1'b0;
        end

        if (w_fire && !(&shift_count_q)) begin
            shift_count_d = shift_count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q    <= 1'b0;
            s0_a_q        <= '0;
            s0_b_q        <= '0;
            s0_aluc_q     <= '0;
            s0_ill_q      <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_result_q   <= '0;
            s1_ill_q      <= 1'b0;
            shift_count_q <= '0;
        end else begin
            s0_valid_q    <= s0_valid_d;
            s0_a_q        <= s0_a_d;
            s0_b_q        <= s0_b_d;
            s0_aluc_q     <= s0_aluc_d;
            s0_ill_q      <= s0_ill_d;
            s1_valid_q    <= s1_valid_d;
            s1_result_q   <= s1_result_d;
            s1_ill_q      <= s1_ill_d;
            shift_count_q <= shift_count_d;
        end
    end

    assign sh_a        = s0_a_q;
    assign sh_b        = s0_b_q;
    assign sh_aluc     = s0_aluc_q;
    assign out_valid   = s1_valid_q;
    assign out_result  = s1_result_q;
    assign out_illegal = s1_ill_q;
    assign shift_count = shift_count_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_issue_stage
//  Brief    : Self-checking bench: transaction-queue model plus directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_issue_stage;

    localparam int COUNT_W = 4;
    localparam int C_MAX   = (1 << COUNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [5:0]         funct;
    logic [4:0]         shamt;
    logic [31:0]        rs_val;
    logic [31:0]        rt_val;
    logic [31:0]        sh_a;
    logic [4:0]         sh_b;
    logic [1:0]         sh_aluc;
    logic [31:0]        sh_c;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_result;
    logic               out_illegal;
    logic [COUNT_W-1:0] shift_count;

    int n_checks = 0;
    int n_errors = 0;

    shift_issue_stage #(.COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .shamt(shamt), .rs_val(rs_val), .rt_val(rt_val),
        .sh_a(sh_a), .sh_b(sh_b), .sh_aluc(sh_aluc), .sh_c(sh_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_illegal(out_illegal),
        .shift_count(shift_count)
    );

    always #5 clk = ~clk;

    // Barrel shifter the stage feeds.
    always_comb begin
        case (sh_aluc)
            2'b00:   sh_c = $unsigned($signed(sh_a) >>> sh_b);
            2'b10:   sh_c = sh_a >> sh_b;
            default: sh_c = sh_a << sh_b;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What an instruction should compute, straight from the MIPS semantics.
    function automatic logic [32:0] ref_op(input logic [5:0] f, input logic [4:0] sa,
                                           input logic [31:0] rs, input logic [31:0] rt);
        int amt;
        amt = int'(f[2] ? rs[4:0] : sa);
        case (f)
            6'b000000, 6'b000100: return {1'b0, rt << amt};
            6'b000010, 6'b000110: return {1'b0, rt >> amt};
            6'b000011, 6'b000111: return {1'b0, $unsigned($signed(rt) >>> amt)};
            default:              return {1'b1, rt};
        endcase
    endfunction

    typedef struct {
        logic [31:0] res;
        bit          ill;
        int          age;
    } txn_t;

    txn_t q[$];
    int   m_count = 0;
    bit   m_fire, m_acc, chk_en = 0;
    logic [32:0] m_op;

    function automatic bit exp_out_valid();
        return (q.size() > 0) && (q[0].age >= 1);
    endfunction

    // Model: up to two requests in flight, each visible one edge after acceptance.
    always @(posedge clk) begin
        chk_en = 1;
        if (rst) begin
            q.delete();
            m_count = 0;
        end else begin
            m_fire = exp_out_valid() && out_ready;
            m_acc  = in_valid && ((q.size() < 2) || out_ready);
            if (m_fire) begin
                if (!q[0].ill && m_count != C_MAX) m_count++;
                void'(q.pop_front());
            end
            foreach (q[i]) q[i].age++;
            if (m_acc) begin
                m_op = ref_op(funct, shamt, rs_val, rt_val);
                q.push_back('{res: m_op[31:0], ill: m_op[32], age: 0});
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !rst && ((q.size() < 2) || out_ready)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_out_valid()});
            chk("shift_count", 32'(shift_count), 32'(m_count));
            if (exp_out_valid()) begin
                chk("out_result", out_result, q[0].res);
                chk("out_illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
            end
        end
    end

    // Holds the request until accepted; returns just after the accepting edge.
    task automatic send(input logic [5:0] f, input logic [4:0] sa,
                        input logic [31:0] rs, input logic [31:0] rt);
        int n;
        in_valid = 1'b1; funct = f; shamt = sa; rs_val = rs; rt_val = rt;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            n++;
            if (n > 50) begin
                chk("send_timeout", 32'd0, 32'd1);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic run_one(input string name, input logic [5:0] f, input logic [4:0] sa,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] exp, input logic exp_ill);
        out_ready = 1'b1;
        send(f, sa, rs, rt);
        @(negedge clk);
        chk({name, "_early"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk(name, out_result, exp);
        chk({name, "_ill"}, {31'd0, out_illegal}, {31'd0, exp_ill});
        @(posedge clk); #1;
    endtask

    int cnt_before;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        funct = '0; shamt = '0; rs_val = '0; rt_val = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sh_a", sh_a, 32'd0);
        chk("rst_sh_b", {27'd0, sh_b}, 32'd0);
        chk("rst_sh_aluc", {30'd0, sh_aluc}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        chk("rst_count", 32'(shift_count), 32'd0);
        @(posedge clk); #1;

        run_one("sll31", 6'b000000, 5'd31, 32'd0, 32'h0000_0001, 32'h8000_0000, 1'b0);
        run_one("srav",  6'b000111, 5'd0, 32'hFFFF_FFE4, 32'h8000_0000, 32'hF800_0000, 1'b0);
        run_one("srlv",  6'b000110, 5'd0, 32'hFFFF_FFE4, 32'h8000_0000, 32'h0800_0000, 1'b0);
        run_one("sra0",  6'b000011, 5'd0, 32'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);

        // Backpressure: third request must stall while both slots are full.
        out_ready = 1'b0;
        send(6'b000000, 5'd1, 32'd0, 32'h0000_0001);
        send(6'b000010, 5'd4, 32'd0, 32'h0000_0F00);
        in_valid = 1'b1; funct = 6'b000100; shamt = 5'd0; rs_val = 32'd8; rt_val = 32'h0000_00AB;
        @(negedge clk);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_head", out_result, 32'h0000_0002);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(6'b000100, 5'd0, 32'd8, 32'h0000_00AB);
        repeat (4) @(posedge clk);
        #1;

        cnt_before = int'(shift_count);
        run_one("illegal", 6'b100000, 5'd7, 32'd3, 32'h1234_5678, 32'h1234_5678, 1'b1);
        repeat (2) @(negedge clk);
        chk("illegal_count", 32'(shift_count), 32'(cnt_before));
        @(posedge clk); #1;

        // Reset with both slots occupied.
        out_ready = 1'b0;
        send(6'b000000, 5'd2, 32'd0, 32'h0000_0003);
        send(6'b000000, 5'd3, 32'd0, 32'h0000_0003);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_count", 32'(shift_count), 32'd0);
        chk("midrst_sh_a", sh_a, 32'd0);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_stale", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) send(6'b000000, 5'd1, 32'd0, 32'(i));
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("saturate", 32'(shift_count), 32'd15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
